// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_pkg                                                |
// | Description : Shared types for the execute stage: ALU control codes, |
// |               NZCV flag bundle and operand width.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110
  } alu_ctrl_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // Codes 001 and 111 have no operation assigned.
  function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
    return !((ctrl == 3'b001) || (ctrl == 3'b111));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_core                                               |
// | Description : Purely combinational ALU. Computes result and NZCV for |
// |               the given control code and flags unassigned codes.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_core #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic [2:0]        ctrl_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output alu_pkg::alu_flags_t flags_o,
  output logic              illegal_o
);
  import alu_pkg::*;

  logic              is_sub;
  logic [DATA_W-1:0] b_opnd;
  logic [DATA_W:0]   sum;
  logic              sum_ovf;

  // Shared adder: subtraction is A + ~B + 1 so carry-out means "no borrow".
  always_comb begin
    is_sub  = (ctrl_i == ALU_SUB);
    b_opnd  = is_sub ? ~b_i : b_i;
    sum     = {1'b0, a_i} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, is_sub};
    sum_ovf = (a_i[DATA_W-1] == b_opnd[DATA_W-1]) &&
              (sum[DATA_W-1] != a_i[DATA_W-1]);
  end

  // Result mux and flag generation; C and V are only meaningful for add/sub.
  always_comb begin
    result_o  = '0;
    flags_o   = '0;
    illegal_o = !is_legal_ctrl(ctrl_i);
    case (ctrl_i)
      ALU_PASS_B: result_o = b_i;
      ALU_ADD, ALU_SUB: begin
        result_o  = sum[DATA_W-1:0];
        flags_o.c = sum[DATA_W];
        flags_o.v = sum_ovf;
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
    flags_o.n = result_o[DATA_W-1];
    flags_o.z = (result_o == '0);
  end

endmodule
`default_nettype wire

// File: rtl/ex_alu_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ex_alu_stage                                           |
// | Description : Execute stage. Runs alu_core, registers the result in  |
// |               the EX/MEM register behind a valid/ready handshake and |
// |               holds the architectural NZCV register.                 |
// |               Optional macro EX_ILLEGAL_TRAP_EN adds a sticky        |
// |               illegal_op trap output.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ex_alu_stage #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ALU_ctrl,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              set_flags,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              reg_write_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [REG_W-1:0]  rd_out,
  output logic              reg_write_out,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_c,
  output logic              cond_lt
`ifdef EX_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_op
`endif
);
  import alu_pkg::*;

  logic [DATA_W-1:0] alu_result;
  alu_flags_t        alu_flags;
  logic              alu_illegal;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q,    result_d;
  logic [REG_W-1:0]  rd_q,        rd_d;
  logic              reg_write_q, reg_write_d;
  alu_flags_t        flags_q,     flags_d;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .ctrl_i    (ALU_ctrl),
    .a_i       (op_a),
    .b_i       (op_b),
    .result_o  (alu_result),
    .flags_o   (alu_flags),
    .illegal_o (alu_illegal)
  );

  // Ready whenever the output slot is empty or being drained this cycle.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready && !flush;
  end

  // Next state: flush wins, then accept (may overlap a drain), then drain.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    flags_d     = flags_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_result;
      rd_d        = rd_in;
      reg_write_d = reg_write_in && !alu_illegal;
      if (set_flags && !alu_illegal) begin
        flags_d = alu_flags;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // EX/MEM pipeline register and architectural flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      flags_q     <= flags_d;
    end
  end

`ifdef EX_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap: set on accepting an unassigned code, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_q <= 1'b0;
    end else if (accept && alu_illegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q;
`endif

  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q;
  assign flag_n        = flags_q.n;
  assign flag_z        = flags_q.z;
  assign flag_c        = flags_q.c;
  assign flag_v        = flags_q.v;
  assign cond_lt       = flags_q.n ^ flags_q.v;

endmodule
`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ex_alu_stage                                        |
// | Description : Self-checking bench for ex_alu_stage: directed vector  |
// |               table, handshake/flush/illegal sequences and random    |
// |               traffic against a cycle-level reference model.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ex_alu_stage;

  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -66'sh0_8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [2:0]  ALU_ctrl;
  logic [63:0] op_a, op_b;
  logic        set_flags;
  logic [4:0]  rd_in;
  logic        reg_write_in, flush;
  logic        out_valid, out_ready;
  logic [63:0] result;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        flag_n, flag_z, flag_v, flag_c, cond_lt;
`ifdef EX_ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  always #5 clk = ~clk;

  ex_alu_stage #(.DATA_W(64), .REG_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ALU_ctrl      (ALU_ctrl),
    .op_a          (op_a),
    .op_b          (op_b),
    .set_flags     (set_flags),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .flag_n        (flag_n),
    .flag_z        (flag_z),
    .flag_v        (flag_v),
    .flag_c        (flag_c),
    .cond_lt       (cond_lt)
`ifdef EX_ILLEGAL_TRAP_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_valid;
  logic [63:0] m_res;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic [3:0]  m_nzcv;
  logic        m_ill;

  typedef struct {
    logic [2:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic        sf;
    logic [63:0] res;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural meaning of each code, in plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic [3:0] nzcv, output logic ill);
    logic signed [65:0] s;
    logic [64:0]        wide;
    logic               cf, vf;
    ill = 1'b0; cf = 1'b0; vf = 1'b0; r = '0;
    case (c)
      3'b000: r = b;
      3'b010: begin
        r    = a + b;
        wide = {1'b0, a} + {1'b0, b};
        cf   = wide[64];
        s    = $signed(a) + $signed(b);
        vf   = (s > SMAX) || (s < SMIN);
      end
      3'b011: begin
        r  = a - b;
        cf = (a >= b);
        s  = $signed(a) - $signed(b);
        vf = (s > SMAX) || (s < SMIN);
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: ill = 1'b1;
    endcase
    nzcv = {r[63], (r == 64'd0), cf, vf};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_res = '0; m_rd = '0; m_rw = 1'b0; m_nzcv = '0; m_ill = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("result", result, m_res);
      chk("rd_out", rd_out, m_rd);
      chk("reg_write_out", reg_write_out, m_rw);
    end
    chk("nzcv", {flag_n, flag_z, flag_c, flag_v}, m_nzcv);
    chk("cond_lt", cond_lt, m_nzcv[3] ^ m_nzcv[0]);
`ifdef EX_ILLEGAL_TRAP_EN
    chk("illegal_op", illegal_op, m_ill);
`endif
  endtask

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  // Entered and left at posedge+1.
  task automatic cyc(input logic v, input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                     input logic sf, input logic [4:0] rd, input logic rw, input logic fl,
                     input logic ordy);
    logic [63:0] r;
    logic [3:0]  f;
    logic        ill, rdy, acc;
    in_valid = v; ALU_ctrl = c; op_a = a; op_b = b; set_flags = sf;
    rd_in = rd; reg_write_in = rw; flush = fl; out_ready = ordy;
    #1;
    rdy = !m_valid || ordy;
    chk("in_ready", in_ready, rdy);
    ref_op(c, a, b, r, f, ill);
    acc = v && rdy && !fl;
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_res = r; m_rd = rd; m_rw = rw && !ill;
    end else if (ordy) m_valid = 1'b0;
    if (acc && sf && !ill) m_nzcv = f;
    if (acc && ill) m_ill = 1'b1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom_range(0, 7));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0] pre;
    tbl[0] = '{3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 4'b1001};
    tbl[1] = '{3'b011, 64'd5, 64'd5, 1'b1, 64'd0, 4'b0110};
    tbl[2] = '{3'b011, 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    tbl[3] = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 4'b0110};
    tbl[4] = '{3'b011, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    tbl[5] = '{3'b100, 64'h0000_0000_0000_FF00, 64'h0000_0000_0000_0FF0, 1'b1, 64'h0000_0000_0000_0F00, 4'b0000};
    tbl[6] = '{3'b101, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h8000_0000_0000_0001, 4'b1000};
    tbl[7] = '{3'b110, 64'h1234, 64'h1234, 1'b1, 64'd0, 4'b0100};
    tbl[8] = '{3'b000, 64'd7, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001, 4'b1000};
    tbl[9] = '{3'b010, 64'd2, 64'd3, 1'b0, 64'd5, 4'b1000};

    // Reset
    reset_n = 1'b0; in_valid = 0; ALU_ctrl = 0; op_a = 0; op_b = 0; set_flags = 0;
    rd_in = 0; reg_write_in = 0; flush = 0; out_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 64'd0);
    chk("rst_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_reg_write", reg_write_out, 1'b0);
`ifdef EX_ILLEGAL_TRAP_EN
    chk("rst_illegal", illegal_op, 1'b0);
`endif
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].sf, 5'(i + 1), 1'b1, 1'b0, 1'b1);
      chk("tbl_result", result, tbl[i].res);
      chk("tbl_nzcv", {flag_n, flag_z, flag_c, flag_v}, tbl[i].nzcv);
      chk("tbl_cond_lt", cond_lt, tbl[i].nzcv[3] ^ tbl[i].nzcv[0]);
    end

    // Flush an ANDS that would set Z: no entry, flags keep 1000
    cyc(1'b1, 3'b100, 64'd1, 64'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b1000);
    // Flush a held output
    cyc(1'b1, 3'b010, 64'd7, 64'd8, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'b010, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("flush_held_valid", out_valid, 1'b0);

    // Backpressure: first result holds while later ADDs wait
    cyc(1'b1, 3'b010, 64'd10, 64'd1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 3'b010, 64'd20, 64'd1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
      chk("bp_hold_result", result, 64'd11);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    cyc(1'b1, 3'b010, 64'd20, 64'd1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1);
    chk("bp_drain1", result, 64'd21);
    cyc(1'b1, 3'b010, 64'd30, 64'd1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
    chk("bp_drain2", result, 64'd31);
    chk("bp_drain2_valid", out_valid, 1'b1);
    cyc(1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("bp_empty", out_valid, 1'b0);

    // Illegal codes
    pre = {flag_n, flag_z, flag_c, flag_v};
    cyc(1'b1, 3'b111, 64'd5, 64'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("ill_result", result, 64'd0);
    chk("ill_reg_write", reg_write_out, 1'b0);
    chk("ill_valid", out_valid, 1'b1);
    chk("ill_nzcv", {flag_n, flag_z, flag_c, flag_v}, pre);
    cyc(1'b1, 3'b001, 64'd1, 64'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
    chk("ill001_reg_write", reg_write_out, 1'b0);
    chk("ill001_nzcv", {flag_n, flag_z, flag_c, flag_v}, pre);
    cyc(1'b1, 3'b010, 64'd1, 64'd1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
`ifdef EX_ILLEGAL_TRAP_EN
    chk("ill_sticky", illegal_op, 1'b1);
`endif

    // Reset mid-operation, with an entry held
    cyc(1'b1, 3'b011, 64'd1, 64'd9, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
`ifdef EX_ILLEGAL_TRAP_EN
    chk("midrst_illegal", illegal_op, 1'b0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Random traffic against the model
    for (int t = 0; t < 400; t++) begin
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd64(), rnd64(),
          1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
